// File: rtl/multi_timer_periph.sv
// multi_timer_periph
//   N_CH independent countdown timers counting whole seconds, where one
//   second is TICK_DIV clk cycles. Each channel exposes four registers
//   selected by addr = {channel, reg[1:0]}:
//     0 LOAD   (W)   value V; V>0 starts a countdown, V=0 flags done at once
//     1 CTRL   (R/W) bit0 auto_reload, bit1 irq_en, bit2 stop (write-only pulse)
//     2 STATUS (R)   bit0 done, bit1 running; (W) bit0 write-1-to-clear done
//     3 COUNT  (R)   remaining seconds
// Ports
//   clk    : single clock, all logic on the rising edge
//   reset  : synchronous active-high reset
//   we/re  : register write / read strobes
//   addr   : {channel, reg}
//   wdata  : write data
//   rdata  : registered read data, updated one cycle after re, held otherwise
//   done   : sticky per-channel done flags
//   irq    : OR of (done & irq_en)
module multi_timer_periph #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 32,
  parameter int TICK_DIV = 10_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic                      re,
  input  logic [$clog2(N_CH)+1:0]   addr,
  input  logic [CNT_W-1:0]          wdata,
  output logic [CNT_W-1:0]          rdata,
  output logic [N_CH-1:0]           done,
  output logic                      irq
);

  localparam int AW = $clog2(N_CH) + 2;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Address decode shared by all channels
  logic [AW-1:0]    w_ch_idx;
  logic [CW-1:0]    w_ch_sel;
  logic [1:0]       w_reg;
  logic             w_ch_ok;

  assign w_ch_idx = addr >> 2;
  assign w_ch_sel = w_ch_idx[CW-1:0];
  assign w_reg    = addr[1:0];
  assign w_ch_ok  = (w_ch_idx < AW'(N_CH));

  // Per-channel state exported for the read mux and irq
  logic [CNT_W-1:0] w_count [N_CH];
  logic [N_CH-1:0]  w_auto;
  logic [N_CH-1:0]  w_irq_en;
  logic [N_CH-1:0]  w_running;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : gen_ch
      state_t           r_state;
      logic [CNT_W-1:0] r_count;
      logic [CNT_W-1:0] r_reload;
      logic [PW-1:0]    r_pre;
      logic             r_auto;
      logic             r_irq_en;
      logic             r_done;

      logic w_sel, w_wr_load, w_wr_ctrl, w_wr_stat;
      logic w_load_zero, w_stop, w_tick, w_expire, w_done_set;

      assign w_sel       = we && w_ch_ok && (w_ch_idx == AW'(gi));
      assign w_wr_load   = w_sel && (w_reg == 2'd0);
      assign w_wr_ctrl   = w_sel && (w_reg == 2'd1);
      assign w_wr_stat   = w_sel && (w_reg == 2'd2);
      assign w_load_zero = w_wr_load && (wdata == '0);
      assign w_stop      = w_wr_ctrl && wdata[2];
      assign w_tick      = (r_state == ST_RUN) && (r_pre == PRE_LAST);
      assign w_expire    = w_tick && (r_count == CNT_W'(1));
      // A LOAD or stop in the expiry cycle cancels the expiry; done-set
      // beats a same-cycle W1C clear.
      assign w_done_set  = w_load_zero || (w_expire && !w_wr_load && !w_stop);

      always_ff @(posedge clk) begin
        if (reset) begin
          r_state  <= ST_IDLE;
          r_count  <= '0;
          r_reload <= '0;
          r_pre    <= '0;
          r_auto   <= 1'b0;
          r_irq_en <= 1'b0;
          r_done   <= 1'b0;
        end else begin
          if (w_wr_load) begin
            r_pre <= '0;
            if (wdata != '0) begin
              r_reload <= wdata;
              r_count  <= wdata;
              r_state  <= ST_RUN;
            end else begin
              r_count  <= '0;
              r_state  <= ST_IDLE;
            end
          end else if (w_stop) begin
            // Count is frozen; a fresh LOAD is needed to restart.
            r_state <= ST_IDLE;
            r_pre   <= '0;
          end else if (r_state == ST_RUN) begin
            if (w_tick) begin
              r_pre <= '0;
              if (w_expire) begin
                if (r_auto) begin
                  r_count <= r_reload;
                end else begin
                  r_count <= '0;
                  r_state <= ST_IDLE;
                end
              end else begin
                r_count <= r_count - CNT_W'(1);
              end
            end else begin
              r_pre <= r_pre + PW'(1);
            end
          end

          if (w_wr_ctrl) begin
            r_auto   <= wdata[0];
            r_irq_en <= wdata[1];
          end

          if (w_done_set) begin
            r_done <= 1'b1;
          end else if (w_wr_stat && wdata[0]) begin
            r_done <= 1'b0;
          end
        end
      end

      assign w_count[gi]   = r_count;
      assign w_auto[gi]    = r_auto;
      assign w_irq_en[gi]  = r_irq_en;
      assign w_running[gi] = (r_state == ST_RUN);
      assign done[gi]      = r_done;
    end
  endgenerate

  assign irq = |(done & w_irq_en);

  // Registered read port; holds its value between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      if (!w_ch_ok) begin
        rdata <= '0;
      end else begin
        case (w_reg)
          2'd1:    rdata <= CNT_W'({w_irq_en[w_ch_sel], w_auto[w_ch_sel]});
          2'd2:    rdata <= CNT_W'({w_running[w_ch_sel], done[w_ch_sel]});
          2'd3:    rdata <= w_count[w_ch_sel];
          default: rdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_timer_periph.sv
// Directed testbench for multi_timer_periph with TICK_DIV=4, N_CH=4, CNT_W=32.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_multi_timer_periph;

  localparam int N_CH     = 4;
  localparam int CNT_W    = 32;
  localparam int TICK_DIV = 4;

  localparam logic [1:0] R_LOAD = 2'd0;
  localparam logic [1:0] R_CTRL = 2'd1;
  localparam logic [1:0] R_STAT = 2'd2;
  localparam logic [1:0] R_CNT  = 2'd3;

  logic             clk;
  logic             reset;
  logic             we;
  logic             re;
  logic [3:0]       addr;
  logic [CNT_W-1:0] wdata;
  logic [CNT_W-1:0] rdata;
  logic [N_CH-1:0]  done;
  logic             irq;

  int n_total = 0;
  int n_bad   = 0;

  multi_timer_periph #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .re   (re),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .done (done),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] rg, input logic [31:0] val);
    we    = 1'b1;
    addr  = {ch, rg};
    wdata = val;
    cyc(1);
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input logic [1:0] ch, input logic [1:0] rg, output logic [31:0] val);
    re   = 1'b1;
    addr = {ch, rg};
    cyc(1);
    re   = 1'b0;
    val  = rdata;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    re    = 1'b0;
    addr  = '0;
    wdata = '0;
    cyc(3);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_irq",   32'(irq),   32'h0);
    chk("rst_rdata", rdata,      32'h0);
    reset = 1'b0;
    cyc(1);
    rd(2'd0, R_CNT, v);
    chk("rst_count0", v, 32'h0);

    // ch0: V=3 -> done exactly 12 cycles after the LOAD edge
    wr(2'd0, R_LOAD, 32'd3);
    cyc(11);
    chk("ch0_done_at_11", 32'(done[0]), 32'h0);
    cyc(1);
    chk("ch0_done_at_12", 32'(done[0]), 32'h1);
    chk("ch0_irq_masked", 32'(irq), 32'h0);
    rd(2'd0, R_STAT, v);
    chk("ch0_status", v, 32'h1);
    rd(2'd0, R_CNT, v);
    chk("ch0_count", v, 32'h0);

    // ch1: auto_reload + irq_en, V=2
    wr(2'd1, R_CTRL, 32'h3);
    wr(2'd1, R_LOAD, 32'd2);
    cyc(7);
    chk("ch1_done_at_7", 32'(done[1]), 32'h0);
    chk("ch1_irq_at_7",  32'(irq),     32'h0);
    cyc(1);
    chk("ch1_done_at_8", 32'(done[1]), 32'h1);
    chk("ch1_irq_at_8",  32'(irq),     32'h1);
    wr(2'd1, R_STAT, 32'h1);
    chk("ch1_w1c_done", 32'(done[1]), 32'h0);
    chk("ch1_w1c_irq",  32'(irq),     32'h0);
    cyc(6);
    chk("ch1_done_at_15", 32'(done[1]), 32'h0);
    cyc(1);
    chk("ch1_done_at_16", 32'(done[1]), 32'h1);
    rd(2'd1, R_CNT, v);
    chk("ch1_count_reload", v, 32'd2);
    rd(2'd1, R_STAT, v);
    chk("ch1_status_run", v, 32'h3);
    rd(2'd1, R_CTRL, v);
    chk("ch1_ctrl", v, 32'h3);
    wr(2'd1, R_CTRL, 32'h4);
    rd(2'd1, R_CTRL, v);
    chk("ch1_ctrl_stop_reads0", v, 32'h0);
    rd(2'd1, R_STAT, v);
    chk("ch1_status_stopped", v, 32'h1);
    wr(2'd1, R_STAT, 32'h1);

    // ch2: V=0 sets done immediately; LOAD beats an expiring tick
    wr(2'd2, R_LOAD, 32'd0);
    chk("ch2_load0_done", 32'(done[2]), 32'h1);
    wr(2'd2, R_STAT, 32'h1);
    chk("ch2_w1c", 32'(done[2]), 32'h0);
    wr(2'd2, R_LOAD, 32'd1);
    cyc(3);
    wr(2'd2, R_LOAD, 32'd5);   // lands on the edge where count=1 would expire
    chk("ch2_load_wins_done", 32'(done[2]), 32'h0);
    rd(2'd2, R_CNT, v);
    chk("ch2_count_5", v, 32'd5);
    cyc(18);
    chk("ch2_done_at_19", 32'(done[2]), 32'h0);
    wr(2'd2, R_STAT, 32'h1);   // W1C on the expiry edge (20 cycles after LOAD 5)
    chk("ch2_done_beats_w1c", 32'(done[2]), 32'h1);
    rd(2'd2, R_STAT, v);
    chk("ch2_status_idle", v, 32'h1);

    // ch3: V=10, stop 9 cycles after LOAD
    wr(2'd3, R_LOAD, 32'd10);
    cyc(8);
    wr(2'd3, R_CTRL, 32'h4);
    rd(2'd3, R_CNT, v);
    chk("ch3_count_held", v, 32'd8);
    rd(2'd3, R_STAT, v);
    chk("ch3_status_stopped", v, 32'h0);
    cyc(100);
    chk("ch3_no_done", 32'(done[3]), 32'h0);
    chk("done_vector", 32'(done), 32'h5);

    // Reset mid-run, with a same-cycle LOAD that must be ignored
    wr(2'd2, R_CTRL, 32'h2);
    chk("irq_ch2", 32'(irq), 32'h1);
    wr(2'd0, R_LOAD, 32'd2);
    rd(2'd0, R_CNT, v);
    chk("ch0_count_loaded", v, 32'd2);
    cyc(3);
    chk("rdata_hold", rdata, 32'd2);
    reset = 1'b1;
    we    = 1'b1;
    addr  = {2'd3, R_LOAD};
    wdata = 32'd7;
    cyc(1);
    reset = 1'b0;
    we    = 1'b0;
    wdata = '0;
    chk("mid_rst_done",  32'(done), 32'h0);
    chk("mid_rst_irq",   32'(irq),  32'h0);
    chk("mid_rst_rdata", rdata,     32'h0);
    cyc(50);
    chk("post_rst_no_done", 32'(done), 32'h0);
    rd(2'd3, R_CNT, v);
    chk("post_rst_count3", v, 32'h0);
    rd(2'd0, R_STAT, v);
    chk("post_rst_status0", v, 32'h0);
    rd(2'd2, R_CTRL, v);
    chk("post_rst_ctrl2", v, 32'h0);

    // Two channels expiring on the same edge
    wr(2'd0, R_LOAD, 32'd2);
    cyc(3);
    wr(2'd1, R_LOAD, 32'd1);
    cyc(3);
    chk("simul_before", 32'(done), 32'h0);
    cyc(1);
    chk("simul_expiry", 32'(done), 32'h3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
